gso_angle_calc: RTL and testbench
=================================

GSO_ANGLE_CALC -- requirements
Module: gso_angle_calc

Interface
REQ-001 Parameter DATA_WIDTH, default 16, vector element and CORDIC data width (signed).
REQ-002 Parameter ANGLE_WIDTH, default 16, CORDIC angle width (signed).
REQ-003 Parameter N_DIM, default 7, vector length; derived constant K_VECTORS = N_DIM-1.
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port rst_n  input  1  reset: synchronous, active-low.
REQ-006 Port en  input  1  single-cycle start pulse.
REQ-007 Port j_in  input  3  angle-set slot index to write, 0..K_VECTORS-1.
REQ-008 Port w_in_flat  input  DATA_WIDTH*N_DIM  signed vector; element i at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
REQ-009 Port thetas_out_flat  output  ANGLE_WIDTH*K_VECTORS*K_VECTORS  angle bank; angle i of slot j at [(j*K_VECTORS+i+1)*ANGLE_WIDTH-1 -: ANGLE_WIDTH]; feeds gso_top thetas_in_flat directly.
REQ-010 Port norm_out  output  DATA_WIDTH  final accumulated magnitude of the last vector processed.
REQ-011 Port busy  output  1  high from accepted start until done.
REQ-012 Port done  output  1  one-cycle completion pulse.
REQ-013 Port err  output  1  one-cycle pulse, coincident with done, for an illegal j_in.
REQ-014 Ports cordic_vec_en (1), cordic_vec_xin (DATA_WIDTH), cordic_vec_yin (DATA_WIDTH), cordic_vec_angle_calc_en (1)  outputs  drive the CORDIC vectoring port.
REQ-015 Ports cordic_vec_opvld (1), cordic_vec_xout (DATA_WIDTH), vec_angle_out (ANGLE_WIDTH)  inputs  CORDIC vectoring results; xout is gain-compensated magnitude.

Function
REQ-016 Algorithm: acc = w[0]; for i = 0..K_VECTORS-1, vector (xin=acc, yin=w[i+1]); theta[j][i] = vec_angle_out; acc = cordic_vec_xout.
REQ-017 FSM states IDLE, ISSUE, WAIT, STORE, FIN.
REQ-018 IDLE -> ISSUE on en=1 with j_in < K_VECTORS; w_in_flat and j_in latched on that edge; idx cleared to 0; busy rises next cycle.
REQ-019 en=1 with j_in >= K_VECTORS in IDLE: no CORDIC op, bank unchanged, done and err pulse the next cycle.
REQ-020 ISSUE: cordic_vec_en=1 and cordic_vec_angle_calc_en=1 for exactly one cycle with xin/yin registered; -> WAIT.
REQ-021 WAIT: hold until cordic_vec_opvld=1; xin/yin held stable; en=0 on CORDIC port.
REQ-022 STORE: write vec_angle_out to slot j_lat angle idx, load acc from cordic_vec_xout; idx==K_VECTORS-1 -> FIN, else idx+1 -> ISSUE.
REQ-023 FIN: norm_out <= acc, done=1 for one cycle, busy drops; -> IDLE.
REQ-024 Exactly K_VECTORS CORDIC operations per accepted start; never more than one outstanding.
REQ-025 Total latency = K_VECTORS*(L_cordic+2)+2 cycles from en to done, L_cordic = CORDIC issue-to-opvld latency.
REQ-026 en while busy is ignored; no restart, no queueing.
REQ-027 Only the K_VECTORS angles of slot j_lat are written; other slots retain prior values across runs.
REQ-028 cordic_vec_opvld outside WAIT is ignored.
REQ-029 Arithmetic: acc is DATA_WIDTH signed, no extra growth; saturation is the CORDIC's responsibility.
REQ-030 Zero vector: proceeds normally; stored angles are whatever CORDIC returns; no special casing.

Reset
REQ-031 rst_n=0 sampled at a clock edge: state IDLE, bank, norm_out, acc, idx, busy, done, err, all cordic_vec_* outputs to 0.
REQ-032 Reset mid-operation aborts immediately; a CORDIC result arriving afterward is ignored (REQ-028).

Structure
REQ-033 Shared gso package holds K_VECTORS derivation, FSM state encoding, and the slot/angle bit-offset function used by both this block and gso_top.
REQ-034 Single module with no sub-modules; the CORDIC lives outside and is shared via the vectoring port.

Verification
REQ-035 Reset: hold rst_n=0 two cycles with en=1 -> all outputs 0, no cordic_vec_en.
REQ-036 w=(100,0,0,0,0,0,0), j_in=0 -> six angles of 0, norm_out=100, six cordic_vec_en pulses, single done.
REQ-037 w=(100,100,0,0,0,0,0), j_in=2 -> slot 2 angle 0 = +45 deg code, others 0; norm_out within 2 LSB of 141; slots 0,1,3-5 unchanged.
REQ-038 w=(100,110,...,160), j_in=1; en re-pulsed mid-run -> ignored, one done, latency per REQ-025, angles within 2 LSB of the golden model.
REQ-039 en with j_in=6 -> done and err the next cycle, bank unchanged, no CORDIC activity.
REQ-040 rst_n=0 during WAIT, late opvld afterward -> IDLE, bank cleared, no write, no done.

Source files
------------

// File: rtl/gso_pkg.sv
// Shared Gram-Schmidt definitions: vector-count derivation, angle-calc FSM
// encoding and the slot/angle bit-offset helper used to index the angle bank.
package gso_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STORE = 3'd3,
    ST_FIN   = 3'd4
  } gso_state_e;

  function automatic int k_vectors(input int n_dim);
    return n_dim - 1;
  endfunction

  // LSB position of angle idx within slot in a flattened k*k angle bank.
  function automatic int theta_lsb(input int slot, input int idx, input int k, input int aw);
    return (slot * k + idx) * aw;
  endfunction

endpackage

// File: rtl/gso_angle_calc.sv
// Derives the Givens angle set for one vector by chaining CORDIC vectoring
// operations, storing the angles into a selectable slot of a persistent bank.
module gso_angle_calc
  import gso_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 16,
  parameter int N_DIM       = 7
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             en,
  input  logic [2:0]                                       j_in,
  input  logic [DATA_WIDTH*N_DIM-1:0]                      w_in_flat,
  output logic [ANGLE_WIDTH*(N_DIM-1)*(N_DIM-1)-1:0]       thetas_out_flat,
  output logic signed [DATA_WIDTH-1:0]                     norm_out,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             err,
  output logic                                             cordic_vec_en,
  output logic signed [DATA_WIDTH-1:0]                     cordic_vec_xin,
  output logic signed [DATA_WIDTH-1:0]                     cordic_vec_yin,
  output logic                                             cordic_vec_angle_calc_en,
  input  logic                                             cordic_vec_opvld,
  input  logic signed [DATA_WIDTH-1:0]                     cordic_vec_xout,
  input  logic signed [ANGLE_WIDTH-1:0]                    vec_angle_out
);

  localparam int K_VECTORS = k_vectors(N_DIM);
  localparam int IDX_W     = (K_VECTORS > 1) ? $clog2(K_VECTORS) : 1;
  localparam int BANK_W    = ANGLE_WIDTH * K_VECTORS * K_VECTORS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K_VECTORS - 1);

  gso_state_e                    r_state;
  logic [DATA_WIDTH*N_DIM-1:0]   r_w;
  logic [2:0]                    r_j;
  logic [IDX_W-1:0]              r_idx;
  logic signed [DATA_WIDTH-1:0]  r_acc;
  logic signed [DATA_WIDTH-1:0]  r_norm;
  logic signed [DATA_WIDTH-1:0]  r_xin;
  logic signed [DATA_WIDTH-1:0]  r_yin;
  logic signed [DATA_WIDTH-1:0]  r_mag_cap;
  logic signed [ANGLE_WIDTH-1:0] r_ang_cap;
  logic [BANK_W-1:0]             r_bank;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_err;
  logic                          r_vec_en;

  logic                          w_j_ok;
  logic signed [DATA_WIDTH-1:0]  w_y_next;

  assign w_j_ok = (int'(j_in) < K_VECTORS);

  // Next y operand: element idx+2 of the latched vector (used when leaving STORE).
  always_comb begin
    // NOTE: default assignment first so every path drives w_y_next and no latch is inferred.
    w_y_next = '0;
    for (int e = 0; e < N_DIM; e++) begin
      if (e == int'(r_idx) + 2) w_y_next = r_w[e*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the angle bank is cleared on reset because downstream consumers read it directly.
      r_state   <= ST_IDLE;
      r_w       <= '0;
      r_j       <= '0;
      r_idx     <= '0;
      r_acc     <= '0;
      r_norm    <= '0;
      r_xin     <= '0;
      r_yin     <= '0;
      r_mag_cap <= '0;
      r_ang_cap <= '0;
      r_bank    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_vec_en  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_vec_en <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (en) begin
            if (w_j_ok) begin
              r_w      <= w_in_flat;
              r_j      <= j_in;
              r_idx    <= '0;
              r_acc    <= w_in_flat[0 +: DATA_WIDTH];
              r_xin    <= w_in_flat[0 +: DATA_WIDTH];
              r_yin    <= w_in_flat[DATA_WIDTH +: DATA_WIDTH];
              r_vec_en <= 1'b1;
              r_busy   <= 1'b1;
              r_state  <= ST_ISSUE;
            end else begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end
          end
        end

        ST_ISSUE: r_state <= ST_WAIT;

        // Results are captured here so the CORDIC may drop opvld immediately.
        ST_WAIT: begin
          if (cordic_vec_opvld) begin
            r_ang_cap <= vec_angle_out;
            r_mag_cap <= cordic_vec_xout;
            r_state   <= ST_STORE;
          end
        end

        ST_STORE: begin
          r_bank[theta_lsb(int'(r_j), int'(r_idx), K_VECTORS, ANGLE_WIDTH) +: ANGLE_WIDTH] <= r_ang_cap;
          r_acc <= r_mag_cap;
          if (r_idx == LAST_IDX) begin
            r_state <= ST_FIN;
          end else begin
            r_idx    <= r_idx + 1'b1;
            r_xin    <= r_mag_cap;
            r_yin    <= w_y_next;
            r_vec_en <= 1'b1;
            r_state  <= ST_ISSUE;
          end
        end

        ST_FIN: begin
          r_norm  <= r_acc;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign thetas_out_flat          = r_bank;
  assign norm_out                 = r_norm;
  assign busy                     = r_busy;
  assign done                     = r_done;
  assign err                      = r_err;
  assign cordic_vec_en            = r_vec_en;
  assign cordic_vec_angle_calc_en = r_vec_en;
  assign cordic_vec_xin           = r_xin;
  assign cordic_vec_yin           = r_yin;

endmodule

// File: tb/tb_gso_angle_calc.sv
// Bench for gso_angle_calc: behavioural CORDIC vectoring responder plus
// table-driven vectors and hand-written reset / illegal-slot sequences.
module tb_gso_angle_calc;

  localparam int DW       = 16;
  localparam int AW       = 16;
  localparam int N        = 7;
  localparam int K        = N - 1;
  localparam int L_CORDIC = 3;
  localparam int EXP_LAT  = K * (L_CORDIC + 2) + 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  en;
  logic [2:0]            j_in;
  logic [DW*N-1:0]       w_in_flat;
  logic [AW*K*K-1:0]     thetas_out_flat;
  logic signed [DW-1:0]  norm_out;
  logic                  busy, done, err;
  logic                  cordic_vec_en, cordic_vec_angle_calc_en;
  logic signed [DW-1:0]  cordic_vec_xin, cordic_vec_yin;
  logic                  cordic_vec_opvld = 1'b0;
  logic signed [DW-1:0]  cordic_vec_xout = '0;
  logic signed [AW-1:0]  vec_angle_out = '0;

  gso_angle_calc #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .N_DIM(N)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .en                       (en),
    .j_in                     (j_in),
    .w_in_flat                (w_in_flat),
    .thetas_out_flat          (thetas_out_flat),
    .norm_out                 (norm_out),
    .busy                     (busy),
    .done                     (done),
    .err                      (err),
    .cordic_vec_en            (cordic_vec_en),
    .cordic_vec_xin           (cordic_vec_xin),
    .cordic_vec_yin           (cordic_vec_yin),
    .cordic_vec_angle_calc_en (cordic_vec_angle_calc_en),
    .cordic_vec_opvld         (cordic_vec_opvld),
    .cordic_vec_xout          (cordic_vec_xout),
    .vec_angle_out            (vec_angle_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input bit ok, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Ideal vectoring CORDIC: binary angle code with pi = 2^15, rounded magnitude.
  function automatic void cordic_ref(input int x, input int y, output int ang, output int mag);
    real a, m;
    a = $atan2(real'(y), real'(x)) * 32768.0 / 3.141592653589793;
    m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    ang = (a >= 0.0) ? $rtoi(a + 0.5) : $rtoi(a - 0.5);
    if (ang > 32767) ang = 32767;
    mag = $rtoi(m + 0.5);
    if (mag > 32767) mag = 32767;
  endfunction

  // CORDIC responder: opvld pulses L_CORDIC cycles after the issue cycle.
  int rsp_cnt = 0;
  int rsp_ang, rsp_mag;
  int n_overlap = 0;
  always @(negedge clk) begin
    cordic_vec_opvld = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        cordic_vec_opvld = 1'b1;
        cordic_vec_xout  = DW'(rsp_mag);
        vec_angle_out    = AW'(rsp_ang);
      end
    end
    if (cordic_vec_en === 1'b1) begin
      if (rsp_cnt > 0) n_overlap++;
      cordic_ref(int'(cordic_vec_xin), int'(cordic_vec_yin), rsp_ang, rsp_mag);
      rsp_cnt = L_CORDIC;
    end
  end

  typedef struct packed {
    logic [DW*N-1:0]     w;
    logic [2:0]          j;
    logic signed [15:0]  exp_norm;
    logic [AW*K-1:0]     exp_ang;
    logic                repulse;
  } vec_t;

  vec_t tbl [5];
  logic [AW*K*K-1:0] exp_bank = '0;

  function automatic logic [DW*N-1:0] mkw(input int a0, input int a1, input int a2, input int a3,
                                          input int a4, input int a5, input int a6);
    return {DW'(a6), DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  function automatic logic [AW*K-1:0] mka(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5);
    return {AW'(a5), AW'(a4), AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [AW*K-1:0] golden_angles(input logic [DW*N-1:0] w);
    logic [AW*K-1:0] r;
    int acc, a, m;
    r = '0;
    acc = int'($signed(w[0 +: DW]));
    for (int i = 0; i < K; i++) begin
      cordic_ref(acc, int'($signed(w[(i+1)*DW +: DW])), a, m);
      r[i*AW +: AW] = AW'(a);
      acc = m;
    end
    return r;
  endfunction

  function automatic int dut_ang(input int j, input int i);
    return int'($signed(thetas_out_flat[(j*K+i)*AW +: AW]));
  endfunction

  function automatic int exp_ang_of(input int j, input int i);
    return int'($signed(exp_bank[(j*K+i)*AW +: AW]));
  endfunction

  // Worst slot/angle deviation from the expected bank, excluding one slot.
  function automatic int bank_dev(input int skip);
    int worst;
    worst = 0;
    for (int j = 0; j < K; j++)
      if (j != skip)
        for (int i = 0; i < K; i++)
          if (absd(dut_ang(j, i), exp_ang_of(j, i)) > worst) worst = absd(dut_ang(j, i), exp_ang_of(j, i));
    return worst;
  endfunction

  task automatic run_vec(input vec_t v, input int tag);
    int n_en, n_done, lat, x0, y0, dev;
    bit err_seen, busy1;
    string s;
    n_en = 0; n_done = 0; lat = -1; x0 = 0; y0 = 0; err_seen = 0; busy1 = 0;
    @(negedge clk);
    en = 1'b1; w_in_flat = v.w; j_in = v.j;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin en = 1'b0; busy1 = busy; end
      if (v.repulse && n == 10) begin en = 1'b1; j_in = 3'd5; w_in_flat = mkw(7, 7, 7, 7, 7, 7, 7); end
      if (v.repulse && n == 11) en = 1'b0;
      if (cordic_vec_en) begin
        n_en++;
        if (n_en == 1) begin x0 = int'(cordic_vec_xin); y0 = int'(cordic_vec_yin); end
      end
      if (err) err_seen = 1'b1;
      if (done) begin n_done++; if (lat < 0) lat = n; end
      if (lat >= 0 && n >= lat + 4) break;
    end
    s = $sformatf("v%0d", tag);
    check({s, " busy after start"}, busy1 == 1'b1, int'(busy1), 1);
    check({s, " latency"}, lat == EXP_LAT, lat, EXP_LAT);
    check({s, " cordic issues"}, n_en == K, n_en, K);
    check({s, " done pulses"}, n_done == 1, n_done, 1);
    check({s, " err"}, err_seen == 1'b0, int'(err_seen), 0);
    check({s, " first xin"}, x0 == int'($signed(v.w[0 +: DW])), x0, int'($signed(v.w[0 +: DW])));
    check({s, " first yin"}, y0 == int'($signed(v.w[DW +: DW])), y0, int'($signed(v.w[DW +: DW])));
    check({s, " norm"}, absd(int'(norm_out), int'(v.exp_norm)) <= 2, int'(norm_out), int'(v.exp_norm));
    for (int i = 0; i < K; i++)
      check($sformatf("%s slot%0d angle%0d", s, v.j, i),
            absd(dut_ang(int'(v.j), i), int'($signed(v.exp_ang[i*AW +: AW]))) <= 2,
            dut_ang(int'(v.j), i), int'($signed(v.exp_ang[i*AW +: AW])));
    dev = bank_dev(int'(v.j));
    check({s, " other slots retained (max dev)"}, dev <= 2, dev, 0);
    exp_bank[int'(v.j)*K*AW +: K*AW] = v.exp_ang;
  endtask

  task automatic run_bad_j(input int jb);
    int dev;
    @(negedge clk);
    en = 1'b1; j_in = 3'(jb); w_in_flat = mkw(100, 100, 100, 100, 100, 100, 100);
    @(negedge clk);
    en = 1'b0;
    check($sformatf("bad j%0d done", jb), done == 1'b1, int'(done), 1);
    check($sformatf("bad j%0d err", jb), err == 1'b1, int'(err), 1);
    check($sformatf("bad j%0d busy", jb), busy == 1'b0, int'(busy), 0);
    check($sformatf("bad j%0d cordic en", jb), cordic_vec_en == 1'b0, int'(cordic_vec_en), 0);
    @(negedge clk);
    check($sformatf("bad j%0d done drops", jb), done == 1'b0 && err == 1'b0, int'({done, err}), 0);
    check($sformatf("bad j%0d no cordic", jb), rsp_cnt == 0 && cordic_vec_en == 1'b0, rsp_cnt, 0);
    dev = bank_dev(-1);
    check($sformatf("bad j%0d bank unchanged (max dev)", jb), dev <= 2, dev, 0);
  endtask

  initial begin
    int n_en_rst, n_bad;
    #200000;
    $display("FAIL global timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n_en_rst, n_bad;
    // Reset held two cycles with en asserted.
    rst_n = 1'b0; en = 1'b1; j_in = 3'd0; w_in_flat = mkw(100, 0, 0, 0, 0, 0, 0);
    n_en_rst = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (cordic_vec_en !== 1'b0) n_en_rst++;
    end
    check("reset no cordic en", n_en_rst == 0, n_en_rst, 0);
    check("reset bank", thetas_out_flat == '0, bank_dev(-1), 0);
    check("reset norm", norm_out == '0, int'(norm_out), 0);
    check("reset busy/done/err", {busy, done, err} == 3'b000, int'({busy, done, err}), 0);
    check("reset cordic outputs",
          {cordic_vec_en, cordic_vec_angle_calc_en, cordic_vec_xin, cordic_vec_yin} == '0,
          int'(cordic_vec_xin), 0);
    en = 1'b0; rst_n = 1'b1;

    tbl[0] = '{w: mkw(100, 0, 0, 0, 0, 0, 0), j: 3'd0, exp_norm: 16'sd100,
               exp_ang: mka(0, 0, 0, 0, 0, 0), repulse: 1'b0};
    tbl[1] = '{w: mkw(100, 100, 0, 0, 0, 0, 0), j: 3'd2, exp_norm: 16'sd141,
               exp_ang: mka(8192, 0, 0, 0, 0, 0), repulse: 1'b0};
    tbl[2] = '{w: mkw(100, 110, 120, 130, 140, 150, 160), j: 3'd1, exp_norm: 16'sd348,
               exp_ang: '0, repulse: 1'b1};
    tbl[2].exp_ang = golden_angles(tbl[2].w);
    tbl[3] = '{w: mkw(0, -100, 0, 0, 0, 0, 0), j: 3'd3, exp_norm: 16'sd100,
               exp_ang: mka(-16384, 0, 0, 0, 0, 0), repulse: 1'b0};
    tbl[4] = '{w: mkw(0, 0, 0, 0, 0, 0, 0), j: 3'd4, exp_norm: 16'sd0,
               exp_ang: mka(0, 0, 0, 0, 0, 0), repulse: 1'b0};

    for (int t = 0; t < 5; t++) run_vec(tbl[t], t);

    run_bad_j(6);
    run_bad_j(7);

    // Reset during WAIT; the CORDIC result then lands while the block is idle.
    @(negedge clk);
    en = 1'b1; j_in = 3'd5; w_in_flat = mkw(100, 100, 100, 100, 100, 100, 100);
    @(negedge clk);
    en = 1'b0;
    check("abort issue seen", cordic_vec_en == 1'b1, int'(cordic_vec_en), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_bank = '0;
    n_bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy || err || cordic_vec_en) n_bad++;
    end
    check("abort no activity after reset", n_bad == 0, n_bad, 0);
    check("abort bank cleared (max dev)", bank_dev(-1) == 0, bank_dev(-1), 0);
    check("abort norm cleared", norm_out == '0, int'(norm_out), 0);
    check("one outstanding cordic op", n_overlap == 0, n_overlap, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
